muldiv_sequencer: RTL and testbench

Multi-cycle controller and datapath for the RV32M operations (MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM, REMU), which the single-cycle ALU does not implement.
- Sits in EX beside the ALU and accepts one operation at a time from the pipeline.
- Runs an iterative 32-step shift-add multiply or restoring divide.
- Holds the pipeline through oStall until the result is ready, and returns it with a one-cycle oDone pulse.

---
 rtl/muldiv_sequencer_pkg.sv | 37 +++
 rtl/muldiv_core.sv | 71 +++++++
 rtl/muldiv_sequencer.sv | 170 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared ALU opcodes and M-extension decode helpers
// Holds the 5-bit ALU opcode space (base ops and the eight RV32M ops) and
// small decode functions used by the sequencer and its users.
package muldiv_sequencer_pkg;

  localparam logic [31:0] ZERO = 32'h0000_0000;

  // Base ALU opcodes handled by the single-cycle ALU.
  localparam logic [4:0] OPADD    = 5'd0;
  localparam logic [4:0] OPSUB    = 5'd1;
  localparam logic [4:0] OPAND    = 5'd2;
  localparam logic [4:0] OPOR     = 5'd3;
  localparam logic [4:0] OPXOR    = 5'd4;

  // M-extension opcodes: multiplies in 16..19, divides in 20..23.
  localparam logic [4:0] OPMUL    = 5'd16;
  localparam logic [4:0] OPMULH   = 5'd17;
  localparam logic [4:0] OPMULHSU = 5'd18;
  localparam logic [4:0] OPMULHU  = 5'd19;
  localparam logic [4:0] OPDIV    = 5'd20;
  localparam logic [4:0] OPDIVU   = 5'd21;
  localparam logic [4:0] OPREM    = 5'd22;
  localparam logic [4:0] OPREMU   = 5'd23;

  function automatic logic is_m_op(input logic [4:0] op);
    return (op >= OPMUL) && (op <= OPREMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= OPDIV) && (op <= OPREMU);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == OPREM) || (op == OPREMU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - iterative shift-add multiply / restoring divide datapath
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture magnitudes, clear the accumulator
//   step            perform one multiply or divide iteration
//   is_div          selects the divide step instead of the multiply step
//   a_mag, b_mag    unsigned operand magnitudes
//   acc_hi, acc_lo  accumulator halves: product {hi,lo}, or remainder hi / quotient lo
module muldiv_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a_mag,
  input  logic [DATA_W-1:0] b_mag,
  output logic [DATA_W-1:0] acc_hi,
  output logic [DATA_W-1:0] acc_lo
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] b_q;

  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   shifted;
  logic              fits;
  logic [DATA_W-1:0] sub_val;

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier bit is set;
    // the carry bit is shifted back into the high half.
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Divide: the partial remainder stays below the divisor, so after the
    // shift it is below twice the divisor and the difference fits in DATA_W bits.
    shifted = {hi_q, lo_q[DATA_W-1]};
    fits    = (shifted >= {1'b0, b_q});
    sub_val = shifted[DATA_W-1:0] - b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else if (load) begin
      hi_q <= '0;
      lo_q <= a_mag;
      b_q  <= b_mag;
    end else if (step) begin
      if (is_div) begin
        if (fits) begin
          hi_q <= sub_val;
          lo_q <= {lo_q[DATA_W-2:0], 1'b1};
        end else begin
          hi_q <= shifted[DATA_W-1:0];
          lo_q <= {lo_q[DATA_W-2:0], 1'b0};
        end
      end else begin
        hi_q <= add_sum[DATA_W:1];
        lo_q <= {add_sum[0], lo_q[DATA_W-1:1]};
      end
    end
  end

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide sequencer
// Ports:
//   iCLK, iRST   clock, asynchronous active-low reset
//   iStart       request, sampled only in IDLE
//   iControl     ALU opcode (one of the OP* M-extension codes)
//   iA, iB       rs1 / rs2 operands
//   iFlush       abort the operation in flight
//   oBusy        high in CALC and FIX
//   oStall       pipeline hold (combinational)
//   oDone        one-cycle result-valid pulse
//   oResult      result, held until the next completed operation
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic [4:0]        iControl,
  input  logic [DATA_W-1:0] iA,
  input  logic [DATA_W-1:0] iB,
  input  logic              iFlush,
  output logic              oBusy,
  output logic              oStall,
  output logic              oDone,
  output logic [DATA_W-1:0] oResult
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_SPECIAL,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]    cnt_q;
  logic [4:0]          op_q;
  logic                neg_q;
  logic [DATA_W-1:0]   spec_q;

  logic                sign_a, sign_b;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic                neg_d;
  logic                special_d;
  logic [DATA_W-1:0]   spec_d;
  logic                accept;

  logic                core_load, core_step, load_res;
  logic [DATA_W-1:0]   acc_hi, acc_lo;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix, fix_val;

  // Operand decode for the request on the inputs this cycle.
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (iControl)
      OPMUL, OPMULH, OPDIV, OPREM: begin
        sign_a = iA[DATA_W-1];
        sign_b = iB[DATA_W-1];
      end
      OPMULHSU: sign_a = iA[DATA_W-1];
      default: ;
    endcase
    a_mag = sign_a ? -iA : iA;
    b_mag = sign_b ? -iB : iB;
    // Truncating division: the remainder takes the dividend's sign.
    neg_d = is_rem_op(iControl) ? sign_a : (sign_a ^ sign_b);

    special_d = 1'b0;
    spec_d    = ZERO;
    if (is_div_op(iControl)) begin
      if (iB == ZERO) begin
        special_d = 1'b1;
        spec_d    = is_rem_op(iControl) ? iA : '1;
      end else if ((iControl == OPDIV || iControl == OPREM) &&
                   iA == {1'b1, {(DATA_W-1){1'b0}}} && iB == '1) begin
        special_d = 1'b1;
        spec_d    = is_rem_op(iControl) ? ZERO : {1'b1, {(DATA_W-1){1'b0}}};
      end
    end
  end

  assign accept = (state_q == ST_IDLE) && iStart && is_m_op(iControl) && !iFlush;

  // State register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = special_d ? ST_SPECIAL : ST_CALC;
      ST_CALC:    if (iFlush) state_d = ST_IDLE;
                  else if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:     state_d = iFlush ? ST_IDLE : ST_DONE;
      ST_SPECIAL: state_d = iFlush ? ST_IDLE : ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and strobe logic
  always_comb begin
    oBusy     = (state_q == ST_CALC) || (state_q == ST_FIX);
    oDone     = (state_q == ST_DONE);
    oStall    = ((state_q == ST_IDLE) && iStart && is_m_op(iControl)) || oBusy;
    core_load = accept;
    core_step = (state_q == ST_CALC) && !iFlush;
    load_res  = ((state_q == ST_FIX) || (state_q == ST_SPECIAL)) && !iFlush;
  end

  // Request capture and iteration counter
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt_q  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      spec_q <= '0;
    end else if (accept) begin
      cnt_q  <= CNT_W'(DATA_W - 1);
      op_q   <= iControl;
      neg_q  <= neg_d;
      spec_q <= spec_d;
    end else if (state_q == ST_CALC) begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  muldiv_core #(.DATA_W(DATA_W)) u_core (
    .clk    (iCLK),
    .rst_n  (iRST),
    .load   (core_load),
    .step   (core_step),
    .is_div (is_div_op(op_q)),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );

  // Sign correction applied in FIX
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_q ? -acc_hi : acc_hi;
    if (is_rem_op(op_q))      fix_val = rem_fix;
    else if (is_div_op(op_q)) fix_val = quo_fix;
    else if (op_q == OPMUL)   fix_val = prod_fix[DATA_W-1:0];
    else                      fix_val = prod_fix[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oResult <= '0;
    end else if (load_res) begin
      oResult <= (state_q == ST_SPECIAL) ? spec_q : fix_val;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  ctl = OPADD;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, stall, done;
  logic [31:0] res;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer dut (
    .iCLK     (clk),
    .iRST     (rst_n),
    .iStart   (start),
    .iControl (ctl),
    .iA       (a),
    .iB       (b),
    .iFlush   (flush),
    .oBusy    (busy),
    .oStall   (stall),
    .oDone    (done),
    .oResult  (res)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic bit ref_is_m(input logic [4:0] op);
    return op inside {OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU};
  endfunction

  function automatic bit ref_special(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    if (!(op inside {OPDIV, OPDIVU, OPREM, OPREMU})) return 1'b0;
    if (y == 32'h0) return 1'b1;
    return (op inside {OPDIV, OPREM}) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
  endfunction

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, sp;
    logic        [63:0] up;
    logic signed [31:0] qx, qy, qr;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    qx = x;
    qy = y;
    case (op)
      OPMUL:    begin sp = sx * sy; return sp[31:0]; end
      OPMULH:   begin sp = sx * sy; return sp[63:32]; end
      OPMULHSU: begin sp = sx * $signed({32'h0, y}); return sp[63:32]; end
      OPMULHU:  begin up = {32'h0, x} * {32'h0, y}; return up[63:32]; end
      OPDIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        qr = qx / qy; return qr;
      end
      OPREM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        qr = qx % qy; return qr;
      end
      OPDIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      OPREMU:   return (y == 0) ? x : x % y;
      default:  return 32'h0;
    endcase
  endfunction

  // Timeline model: idle / working (cycles left until the result) / done pulse.
  int          m_phase = 0;
  int          m_left = 0;
  bit          m_special = 1'b0;
  logic [31:0] m_pend = 32'h0;
  logic [31:0] m_res = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_special = 1'b0; m_pend = 32'h0; m_res = 32'h0;
    end else begin
      case (m_phase)
        0: if (start && ref_is_m(ctl) && !flush) begin
             m_pend    = ref_result(ctl, a, b);
             m_special = ref_special(ctl, a, b);
             m_left    = m_special ? 1 : 33;
             m_phase   = 1;
           end
        1: if (flush) m_phase = 0;
           else begin
             m_left--;
             if (m_left == 0) begin m_res = m_pend; m_phase = 2; end
           end
        default: m_phase = 0;
      endcase
    end
  end

  bit   chk_en = 1'b0;
  logic e_busy, e_stall;

  always @(negedge clk) begin
    if (chk_en) begin
      e_busy  = (m_phase == 1) && !m_special;
      e_stall = ((m_phase == 0) && start && ref_is_m(ctl)) || e_busy;
      check32("cyc_busy",   {31'h0, busy},  {31'h0, e_busy});
      check32("cyc_stall",  {31'h0, stall}, {31'h0, e_stall});
      check32("cyc_done",   {31'h0, done},  {31'h0, (m_phase == 2)});
      check32("cyc_result", res, m_res);
    end
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV] = '{
    '{OPMUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
    '{OPMULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
    '{OPMULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
    '{OPMULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34},
    '{OPMULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 34},
    '{OPDIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34},
    '{OPREM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34},
    '{OPDIVU,   32'hFFFF_FFFE, 32'h0000_0002, 32'h7FFF_FFFF, 34},
    '{OPDIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34},
    '{OPREM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34},
    '{OPDIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 34},
    '{OPREMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 34},
    '{OPDIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2},
    '{OPREMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2},
    '{OPDIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2},
    '{OPREM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2},
    '{OPREM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 2}
  };

  task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat, input int idx);
    int n;
    bit seen;
    @(posedge clk); #2;
    ctl = op; a = x; b = y; start = 1'b1;
    n = 0; seen = 1'b0;
    while (n < 100 && !seen) begin
      @(posedge clk); n++;
      if (n == 1) begin #2; start = 1'b0; end
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL op%0d_timeout: got no done in 100 cycles, want done", idx);
    end else begin
      check32($sformatf("op%0d_latency", idx), n, lat);
      check32($sformatf("op%0d_result", idx), res, exp);
    end
  endtask

  int ndone;

  initial begin
    #3;
    check32("reset_busy",   {31'h0, busy},  32'h0);
    check32("reset_done",   {31'h0, done},  32'h0);
    check32("reset_stall",  {31'h0, stall}, 32'h0);
    check32("reset_result", res, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < NV; i++)
      check32($sformatf("model%0d", i), ref_result(vecs[i].op, vecs[i].x, vecs[i].y), vecs[i].exp);

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].exp, vecs[i].lat, i);

    // Flush a divide mid-calculation.
    @(posedge clk); #2;
    ctl = OPDIVU; a = 32'h0000_0064; b = 32'h0000_0007; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (9) @(posedge clk);
    #2; flush = 1'b1;
    @(posedge clk); #2; flush = 1'b0;
    #1;
    check32("flush_busy", {31'h0, busy}, 32'h0);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    check32("flush_no_done", ndone, 0);
    check32("flush_result_kept", res, vecs[NV-1].exp);
    run_op(OPMUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 100);

    // Reset in the middle of a multiply.
    @(posedge clk); #2;
    ctl = OPMULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check32("midrst_busy",   {31'h0, busy},  32'h0);
    check32("midrst_done",   {31'h0, done},  32'h0);
    check32("midrst_result", res, 32'h0);
    @(posedge clk); #2; rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    check32("midrst_no_done", ndone, 0);

    // Non-M opcode is ignored.
    @(posedge clk); #2;
    ctl = OPADD; a = 32'h1; b = 32'h2; start = 1'b1;
    #1;
    check32("opadd_stall", {31'h0, stall}, 32'h0);
    repeat (3) @(negedge clk);
    check32("opadd_busy", {31'h0, busy}, 32'h0);
    start = 1'b0;

    // Start held through the calculation produces one result.
    @(posedge clk); #2;
    ctl = OPMULHU; a = 32'h8000_0000; b = 32'h0000_0004; start = 1'b1;
    repeat (20) @(posedge clk);
    #2; start = 1'b0;
    ndone = 0;
    repeat (50) begin @(negedge clk); if (done) ndone++; end
    check32("held_one_done", ndone, 1);
    check32("held_result", res, 32'h0000_0002);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
